// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants and the writer FSM state type.
package y86_pkg;

  localparam int MEM_DEPTH_DEFAULT = 1024;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  // Codes C..F are unassigned and rejected by the decoder.
  localparam logic [3:0] ICODE_ERR_MIN = 4'hC;
  localparam logic [3:0] ICODE_ERR_MAX = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } wr_state_t;

endpackage

// File: rtl/y86_ilen.sv
// Combinational icode decode: instruction length, legality, register byte and valC position.
module y86_ilen
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  output logic [3:0] o_len,
  output logic       o_valid,
  output logic       o_has_regs,
  output logic [1:0] o_valc_off
);

  always_comb begin
    o_len      = 4'd1;
    o_valid    = (i_icode < ICODE_ERR_MIN);
    o_has_regs = 1'b0;
    o_valc_off = 2'd0;
    case (i_icode)
      ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: begin
        o_len      = 4'd2;
        o_has_regs = 1'b1;
      end
      ICODE_JXX, ICODE_CALL: begin
        o_len      = 4'd9;
        o_valc_off = 2'd1;
      end
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ: begin
        o_len      = 4'd10;
        o_has_regs = 1'b1;
        o_valc_off = 2'd2;
      end
      default: o_len = 4'd1;
    endcase
  end

endmodule

// File: rtl/y86_instr_writer.sv
// Serialises one Y86-64 instruction per handshake into byte writes to instruction memory.
// Handshake: a transfer happens on a rising edge where in_valid && in_ready; in_valid may not depend on in_ready.
module y86_instr_writer
  import y86_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_addr,
  input  logic [63:0] start_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [63:0] next_pc,
  output logic        instr_done,
  output logic        err_invalid,
  output logic        err_bound,
  output wr_state_t   dbg_state
);

  wr_state_t   r_state;
  wr_state_t   w_state_nxt;
  logic        r_live;
  logic [63:0] r_next_pc;
  logic [3:0]  r_idx;
  logic [3:0]  r_len;
  logic        r_has_regs;
  logic [1:0]  r_valc_off;
  logic [3:0]  r_icode;
  logic [3:0]  r_ifun;
  logic [3:0]  r_ra;
  logic [3:0]  r_rb;
  logic [63:0] r_valc;
  logic        r_err_invalid;
  logic        r_err_bound;

  logic [3:0]  w_len;
  logic        w_valid;
  logic        w_has_regs;
  logic [1:0]  w_valc_off;
  logic        w_hs;
  logic [64:0] w_end;
  logic        w_oob;
  logic        w_accept;
  logic        w_last;
  logic [2:0]  w_k;
  logic [5:0]  w_bit_lo;
  logic [7:0]  w_byte;

  y86_ilen u_ilen (
    .i_icode    (icode),
    .o_len      (w_len),
    .o_valid    (w_valid),
    .o_has_regs (w_has_regs),
    .o_valc_off (w_valc_off)
  );

  // r_live keeps in_ready low until the first edge after reset release.
  assign in_ready = r_live && (r_state == ST_IDLE) && !load_addr;
  assign w_hs     = in_valid && in_ready;
  assign w_end    = {1'b0, r_next_pc} + {61'd0, w_len};
  assign w_oob    = w_end > 65'(MEM_DEPTH);
  assign w_accept = w_hs && w_valid && !w_oob;
  assign w_last   = (r_state == ST_EMIT) && (r_idx == r_len - 4'd1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_EMIT;
      ST_EMIT: if (w_last)   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // valC goes out MSB first; k is the valC byte number counted from the top.
  assign w_k      = r_idx[2:0] - {1'b0, r_valc_off};
  assign w_bit_lo = {3'd7 - w_k, 3'b000};

  always_comb begin
    w_byte = 8'h00;
    if (r_state == ST_EMIT) begin
      if (r_idx == 4'd0)                    w_byte = {r_icode, r_ifun};
      else if (r_has_regs && r_idx == 4'd1) w_byte = {r_ra, r_rb};
      else                                  w_byte = r_valc[w_bit_lo +: 8];
    end
  end

  assign mem_we      = (r_state == ST_EMIT);
  assign mem_addr    = r_next_pc + {60'd0, r_idx};
  assign mem_wdata   = w_byte;
  assign next_pc     = r_next_pc;
  assign instr_done  = w_last;
  assign err_invalid = r_err_invalid;
  assign err_bound   = r_err_bound;
  assign dbg_state   = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_live        <= 1'b0;
      r_next_pc     <= 64'd0;
      r_idx         <= 4'd0;
      r_len         <= 4'd1;
      r_has_regs    <= 1'b0;
      r_valc_off    <= 2'd0;
      r_icode       <= 4'd0;
      r_ifun        <= 4'd0;
      r_ra          <= 4'd0;
      r_rb          <= 4'd0;
      r_valc        <= 64'd0;
      r_err_invalid <= 1'b0;
      r_err_bound   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_live        <= 1'b1;
      r_err_invalid <= w_hs && !w_valid;
      r_err_bound   <= w_hs && w_valid && w_oob;
      case (r_state)
        ST_IDLE: begin
          if (load_addr) begin
            r_next_pc <= start_addr;
          end else if (w_accept) begin
            r_idx      <= 4'd0;
            r_len      <= w_len;
            r_has_regs <= w_has_regs;
            r_valc_off <= w_valc_off;
            r_icode    <= icode;
            r_ifun     <= ifun;
            r_ra       <= rA;
            r_rb       <= rB;
            r_valc     <= valC;
          end
        end
        ST_EMIT: begin
          if (w_last) begin
            r_next_pc <= r_next_pc + {60'd0, r_len};
            r_idx     <= 4'd0;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        default: r_idx <= 4'd0;
      endcase
    end
  end

endmodule

// File: doc/y86_instr_writer.md
Y86_INSTR_WRITER -- requirements
Module: y86_instr_writer

Interface
REQ-001 The module SHALL have parameter MEM_DEPTH, default 1024, meaning the number of instruction-memory bytes, addressed 0..MEM_DEPTH-1.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port load_addr, input, 1 bit: load start_addr into the write-address counter.
REQ-005 The module SHALL have port start_addr, input, 64 bits: new write address.
REQ-006 The module SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: instruction handshake.
REQ-007 The module SHALL have ports icode, ifun, rA and rB, inputs, 4 bits each: instruction fields.
REQ-008 The module SHALL have port valC, input, 64 bits: the constant word.
REQ-009 The module SHALL have ports mem_we (output, 1 bit), mem_addr (output, 64 bits) and mem_wdata (output, 8 bits): a byte write port to instruction memory.
REQ-010 The module SHALL have port next_pc, output, 64 bits: the current write-address counter (the PC of the next instruction).
REQ-011 The module SHALL have port instr_done, output, 1 bit: one-cycle pulse marking the final byte of an instruction.
REQ-012 The module SHALL have ports err_invalid and err_bound, outputs, 1 bit each: one-cycle error pulses.

Function
REQ-013 The FSM SHALL have states IDLE and EMIT; in_ready SHALL be high only in IDLE with load_addr low.
REQ-014 In IDLE, load_addr high SHALL set next_pc to start_addr on the next edge; an in_valid in that same cycle SHALL NOT be accepted.
REQ-015 In EMIT, load_addr SHALL be ignored.
REQ-016 A handshake (in_valid and in_ready) SHALL capture all fields and compute the length: 1 byte for icode 0, 1 and 9; 2 bytes for 2, 6, A and B; 9 bytes for 7 and 8; 10 bytes for 3, 4 and 5.
REQ-017 For icode C..F, the handshake SHALL produce no memory writes, pulse err_invalid on the next cycle, leave next_pc unchanged, and remain in IDLE.
REQ-018 If next_pc + len > MEM_DEPTH, the handshake SHALL produce no writes, pulse err_bound on the next cycle, leave next_pc unchanged, and remain in IDLE.
REQ-019 Otherwise, the FSM SHALL enter EMIT and write exactly one byte per cycle, starting on the cycle after the handshake, with mem_addr equal to next_pc + byte index.
REQ-020 Byte 0 SHALL be {icode, ifun}.
REQ-021 For 2-byte and 10-byte instructions, byte 1 SHALL be {rA, rB}, with fields passed unmodified and no substitution of 0xF.
REQ-022 valC SHALL be emitted most-significant byte first: in bytes 2..9 for 10-byte instructions and in bytes 1..8 for 9-byte instructions.
REQ-023 On the last byte, instr_done SHALL be high in the same cycle; on the following edge, next_pc SHALL increase by len and the FSM SHALL return to IDLE.
REQ-024 Throughput SHALL be len+1 cycles per instruction.
REQ-025 mem_we SHALL be high only in EMIT; when mem_we is low, mem_addr SHALL equal next_pc and mem_wdata SHALL be 0.
REQ-026 Input fields SHALL NOT be sampled after the handshake; changes during EMIT SHALL have no effect.

Reset
REQ-027 While rst_n is low, the module SHALL asynchronously force: state IDLE, next_pc 0, byte index 0, mem_we 0, mem_addr 0, mem_wdata 0, instr_done 0, err_invalid 0, err_bound 0, in_ready 0.
REQ-028 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-029 Reset during EMIT SHALL abort the instruction immediately, with no further writes and no partial next_pc advance.

Structure
REQ-030 Package y86_pkg SHALL hold the icode constants (HALT..POPQ), the error-icode range, and MEM_DEPTH_DEFAULT.
REQ-031 Sub-module y86_ilen SHALL be combinational icode-to-{len, valid, has_regs, valc_offset} decode, shared with the fetch path.

Verification
REQ-032 load_addr with start_addr=0, then OPq icode=6, ifun=0, rA=0, rB=3 -> writes [0]=0x60 and [1]=0x03; instr_done on the second write; next_pc=2.
REQ-033 irmovq icode=3, rA=F, rB=2, valC=0x0000_0000_0000_000F at next_pc=2 -> 10 writes at 2..11: 0x30, 0xF2, 0x00 x7, 0x0F; next_pc=12.
REQ-034 call icode=8, valC=0x0102030405060708 at next_pc=12 -> writes 0x80, 0x01..0x08 at 12..20; next_pc=21; then halt -> [21]=0x00, next_pc=22.
REQ-035 icode=0xD -> no mem_we, err_invalid one pulse, next_pc unchanged; then load_addr start_addr=1020 and rmmovq -> err_bound, no writes; then nop -> [1020]=0x10.
REQ-036 Reset asserted on the 4th byte of a 10-byte instruction -> mem_we drops immediately and next_pc=0; after release, in_ready is high and a new nop writes at address 0.
